// File: rtl/uart_rx_osr_if.sv
// Host-side signals of the oversampling UART receiver: serial line in, byte/status out.
// Combinational bundle only; no latency.
// No backpressure: READ is a one-cycle consume strobe, overruns are flagged instead.
interface uart_rx_osr_if;
    logic       RXD;
    logic       READ;
    logic [7:0] Rx_Data;
    logic       NINTI;
    logic       FERR;
    logic       OVR;

    modport master (
        output RXD,
        output READ,
        input  Rx_Data,
        input  NINTI,
        input  FERR,
        input  OVR
    );

    modport slave (
        input  RXD,
        input  READ,
        output Rx_Data,
        output NINTI,
        output FERR,
        output OVR
    );
endinterface

// File: rtl/uart_rx_osr.sv
// Oversampling 8-bit UART receiver (optional even parity) with a one-byte holding register.
// Latency: byte and NINTI appear one cycle after the stop-bit centre sample (plus 2-flop sync).
// No backpressure: a new good frame overwrites an unread byte and sets the sticky OVR flag.
module uart_rx_osr #(
    parameter int OSR       = 16,
    parameter bit PARITY_EN = 1'b0
) (
    input  logic          Clock,
    input  logic          Reset,
    uart_rx_osr_if.slave  bus
);
    localparam int CW = $clog2(OSR);
    localparam logic [CW-1:0] HALF_M1 = CW'(OSR / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(OSR - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;
    localparam logic [2:0] WAITHI = 3'd5;

    logic [1:0]    sync;
    logic          rxs;
    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shreg;
    logic          bad;
    logic          stop_done;
    logic          good_load;
    logic          bad_frame;
    logic [7:0]    rx_data;
    logic          ninti;
    logic          ferr;
    logic          ovr;

    assign rxs = sync[1];

    // Synchronizer resets to the idle level so a reset never fakes a start edge.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], bus.RXD};
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= 3'd0;
            shreg <= 8'h00;
            bad   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rxs) begin
                        state <= START;
                    end
                end
                START: begin
                    if (cnt == HALF_M1) begin
                        cnt <= '0;
                        if (rxs) begin
                            state <= IDLE;
                        end else begin
                            state <= DATA;
                            idx   <= 3'd0;
                            bad   <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == FULL_M1) begin
                        cnt        <= '0;
                        shreg[idx] <= rxs;
                        idx        <= idx + 3'd1;
                        if (idx == 3'd7) begin
                            state <= PARITY_EN ? PARITY : STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (cnt == FULL_M1) begin
                        cnt   <= '0;
                        state <= STOP;
                        if (rxs != (^shreg)) begin
                            bad <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == FULL_M1) begin
                        cnt   <= '0;
                        state <= (bad || !rxs) ? WAITHI : IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAITHI: begin
                    cnt <= '0;
                    if (rxs) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign stop_done = (state == STOP) && (cnt == FULL_M1);
    assign good_load = stop_done && rxs && !bad;
    assign bad_frame = stop_done && !(rxs && !bad);

    // A load beats a same-cycle READ for NINTI, but READ still suppresses OVR.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            rx_data <= 8'h00;
            ninti   <= 1'b1;
            ferr    <= 1'b0;
            ovr     <= 1'b0;
        end else begin
            if (good_load) begin
                rx_data <= shreg;
                ninti   <= 1'b0;
            end else if (bus.READ) begin
                ninti <= 1'b1;
            end

            if (bus.READ) begin
                ovr <= 1'b0;
            end else if (good_load && !ninti) begin
                ovr <= 1'b1;
            end

            if (bad_frame) begin
                ferr <= 1'b1;
            end else if (bus.READ) begin
                ferr <= 1'b0;
            end
        end
    end

    assign bus.Rx_Data = rx_data;
    assign bus.NINTI   = ninti;
    assign bus.FERR    = ferr;
    assign bus.OVR     = ovr;
endmodule

// File: doc/uart_rx_osr.md
UART_RX_OSR -- requirements
Module: uart_rx_osr

Interface
REQ-001 SHALL have parameter OSR, default 16, giving Clock cycles per serial bit (even, >= 4).
REQ-002 SHALL have parameter PARITY_EN, default 0, where 1 expects an even-parity bit between data bit 7 and stop.
REQ-003 SHALL have port Clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port RXD, input, 1 bit: asynchronous serial line, idle high, 8 data bits LSB first.
REQ-006 SHALL have port READ, input, 1 bit: one-cycle consume strobe from host.
REQ-007 SHALL have port Rx_Data, output, 8 bits: holding register of last accepted byte.
REQ-008 SHALL have port NINTI, output, 1 bit: active-low data-ready interrupt.
REQ-009 SHALL have port FERR, output, 1 bit: sticky framing/parity error flag.
REQ-010 SHALL have port OVR, output, 1 bit: sticky overrun flag.

Function
REQ-011 SHALL pass RXD through a 2-flop synchronizer; all later timing is referenced to the synchronized signal rxs.
REQ-012 SHALL implement states IDLE, START, DATA, PARITY, STOP, WAITHI with a cycle counter (log2(OSR) bits) and a bit index (3 bits).
REQ-013 In IDLE, SHALL enter START on the first cycle rxs = 0 (cycle t0) and clear the counter.
REQ-014 SHALL sample START at t0+OSR/2; if rxs = 1 there (glitch), SHALL return to IDLE with no flag change.
REQ-015 SHALL sample data bit i (0..7) at t0+OSR/2+OSR*(i+1) into shift position i, then go to PARITY if PARITY_EN else STOP.
REQ-016 PARITY SHALL sample at the next bit centre; mismatch with even parity of the 8 data bits marks the frame bad.
REQ-017 STOP SHALL sample at the next bit centre (t0+OSR/2+9*OSR without parity); rxs = 0 marks the frame bad.
REQ-018 Good frame: SHALL load Rx_Data and drive NINTI low on the cycle after the stop sample, then return to IDLE.
REQ-019 Bad frame: SHALL discard the byte, set FERR, leave Rx_Data/NINTI unchanged, go to WAITHI.
REQ-020 WAITHI SHALL remain until rxs = 1 (break tolerance), then enter IDLE.
REQ-021 Good frame while NINTI already low: SHALL overwrite Rx_Data, keep NINTI low, set OVR.
REQ-022 READ = 1: SHALL next cycle drive NINTI high and clear FERR and OVR.
REQ-023 READ on the same cycle as a good-frame load: load wins, NINTI stays low, OVR not set, FERR cleared.
REQ-024 READ while NINTI high SHALL still clear FERR/OVR and otherwise have no effect.
REQ-025 Rx_Data SHALL be stable whenever NINTI is high or no load occurs.
REQ-026 Receiver SHALL accept back-to-back frames with zero idle bits after the stop-bit centre.

Reset
REQ-027 Reset high SHALL immediately force IDLE, counter/index 0, synchronizer flops 1, Rx_Data 8'h00, NINTI 1, FERR 0, OVR 0.
REQ-028 Reset asserted mid-frame SHALL abandon the frame with no flag set; after release reception restarts only on a new falling edge of rxs.

Verification
REQ-029 OSR=16, frame 0xA5 8N1 -> NINTI low 1 cycle after stop sample, Rx_Data = 8'hA5, FERR = OVR = 0.
REQ-030 OSR=16, RXD low for 5 cycles then high -> state back to IDLE, NINTI stays 1, no flags.
REQ-031 Frame 0x3C with stop bit 0, line held low 40 cycles -> FERR = 1, Rx_Data unchanged, next frame 0x81 received only after line returns high.
REQ-032 Frames 0x11 then 0x22 with no READ -> Rx_Data = 8'h22, OVR = 1, NINTI 0; READ -> NINTI 1, OVR 0.
REQ-033 PARITY_EN=1, 0x07 with parity bit 0 (wrong) -> FERR = 1, byte discarded; with parity 1 -> Rx_Data = 8'h07.
REQ-034 Reset pulse during data bit 4 of 0xFF -> all outputs at reset values; following frame 0x5A received correctly.
